// File: rtl/mtsp_if_fetch.sv
// MTSP instruction fetch front end: PC sequencing, credit-limited in-order
// instruction-memory handshake, bundle FIFO and stall/branch-aware issue register.
module mtsp_if_fetch #(
   parameter int PC_WIDTH   = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [PC_WIDTH-1:0] start_pc,
   output logic                busy,
   output logic                done,
   output logic                im_req,
   output logic [PC_WIDTH-1:0] im_addr,
   input  logic                im_grant,
   input  logic                im_valid,
   input  logic [127:0]        im_data,
   input  logic                stall,
   input  logic                branch,
   input  logic [PC_WIDTH-1:0] branch_pc,
   output logic [PC_WIDTH-1:0] pc_out,
   output logic [127:0]        uinstx4_out,
   output logic                inst_valid
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [127:0] BUBBLE = {128{1'b1}};

   logic [1:0]          state_reg, state_next;
   logic [PC_WIDTH-1:0] fetch_pc_reg, resp_pc_reg;
   logic [CW-1:0]       outst_reg, outst_next;
   logic [CW-1:0]       drop_reg, drop_next;
   logic [CW-1:0]       wr_ptr_reg, rd_ptr_reg, occ;
   logic [AW-1:0]       wr_idx, rd_idx;
   logic [CW:0]         inflight;

   logic [PC_WIDTH-1:0] pc_mem   [FIFO_DEPTH];
   logic [127:0]        data_mem [FIFO_DEPTH];

   logic [PC_WIDTH-1:0] pc_out_reg;
   logic [127:0]        uinst_reg;
   logic                valid_reg, done_reg;

   logic start_act, branch_act, flush;
   logic grant, resp, push, pop, fifo_empty, head_end, end_issue;

   // Busy covers the DONE cycle so BUSY drops one cycle after the end bundle issues.
   assign busy       = (state_reg != ST_IDLE) | done_reg;
   assign start_act  = start & ~busy;
   assign branch_act = branch & busy;
   assign flush      = start_act | branch_act;

   assign occ        = wr_ptr_reg - rd_ptr_reg;
   assign wr_idx     = wr_ptr_reg[AW-1:0];
   assign rd_idx     = rd_ptr_reg[AW-1:0];
   assign fifo_empty = (occ == '0);
   assign inflight   = {1'b0, occ} + {1'b0, outst_reg};

   assign im_req  = (state_reg == ST_FETCH) && (inflight < (CW+1)'(FIFO_DEPTH));
   assign im_addr = fetch_pc_reg;
   assign grant   = im_req & im_grant;
   assign resp    = im_valid && (outst_reg != '0);
   assign push    = resp && (state_reg == ST_FETCH) && (drop_reg == '0) && !branch_act;
   assign pop     = !stall && !fifo_empty && !branch_act;

   // Only one bundle with the end bit can ever be queued: its arrival stops further pushes.
   assign head_end  = data_mem[rd_idx][31] && (state_reg == ST_DRAIN);
   assign end_issue = pop && head_end;

   assign outst_next = outst_reg + CW'(grant) - CW'(resp);

   always_comb begin
      state_next = state_reg;
      if (start_act || branch_act) begin
         state_next = ST_FETCH;
      end else begin
         case (state_reg)
            ST_FETCH: if (push && im_data[31]) state_next = ST_DRAIN;
            ST_DRAIN: if (end_issue) state_next = ST_IDLE;
            default:  state_next = state_reg;
         endcase
      end
   end

   // On redirect every request still in flight afterwards is stale, including
   // ones already marked for dropping, so the drop count becomes the in-flight count.
   always_comb begin
      drop_next = drop_reg;
      if (branch_act) begin
         drop_next = outst_next;
      end else if (start_act) begin
         drop_next = '0;
      end else if (resp && (drop_reg != '0)) begin
         drop_next = drop_reg - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= ST_IDLE;
         fetch_pc_reg <= '0;
         resp_pc_reg  <= '0;
         outst_reg    <= '0;
         drop_reg     <= '0;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
      end else begin
         state_reg <= state_next;
         outst_reg <= outst_next;
         drop_reg  <= drop_next;
         if (start_act) begin
            fetch_pc_reg <= start_pc;
            resp_pc_reg  <= start_pc;
         end else if (branch_act) begin
            fetch_pc_reg <= branch_pc;
            resp_pc_reg  <= branch_pc;
         end else begin
            if (grant) fetch_pc_reg <= fetch_pc_reg + 1'b1;
            if (push)  resp_pc_reg  <= resp_pc_reg + 1'b1;
         end
         if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
         end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_idx]   <= resp_pc_reg;
         data_mem[wr_idx] <= im_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_out_reg <= '0;
         uinst_reg  <= BUBBLE;
         valid_reg  <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         done_reg <= end_issue;
         if (branch_act) begin
            uinst_reg <= BUBBLE;
            valid_reg <= 1'b0;
         end else if (!stall) begin
            if (pop) begin
               pc_out_reg <= pc_mem[rd_idx];
               uinst_reg  <= data_mem[rd_idx];
               valid_reg  <= 1'b1;
            end else begin
               uinst_reg <= BUBBLE;
               valid_reg <= 1'b0;
            end
         end
      end
   end

   assign pc_out      = pc_out_reg;
   assign uinstx4_out = uinst_reg;
   assign inst_valid  = valid_reg;
   assign done        = done_reg;

   fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && (occ == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_mtsp_if_fetch.sv
// Randomized bench for mtsp_if_fetch: in-order memory model with random grant and
// latency, expected PC stream per program/redirect, decoupled output monitor.
module tb_mtsp_if_fetch;
   localparam int PW    = 16;
   localparam int DEPTH = 4;
   localparam logic [127:0] ONES = {128{1'b1}};

   logic           clk       = 1'b0;
   logic           rst_n     = 1'b1;
   logic           start     = 1'b0;
   logic           stall     = 1'b0;
   logic           branch    = 1'b0;
   logic           im_grant  = 1'b0;
   logic           im_valid  = 1'b0;
   logic [PW-1:0]  start_pc  = '0;
   logic [PW-1:0]  branch_pc = '0;
   logic [127:0]   im_data   = '0;
   logic           busy, done, im_req, inst_valid;
   logic [PW-1:0]  im_addr, pc_out;
   logic [127:0]   uinstx4_out;

   always #5 clk = ~clk;

   mtsp_if_fetch #(.PC_WIDTH(PW), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc),
      .busy(busy), .done(done), .im_req(im_req), .im_addr(im_addr),
      .im_grant(im_grant), .im_valid(im_valid), .im_data(im_data),
      .stall(stall), .branch(branch), .branch_pc(branch_pc),
      .pc_out(pc_out), .uinstx4_out(uinstx4_out), .inst_valid(inst_valid)
   );

   typedef struct {
      logic [PW-1:0] pc;
      logic [127:0]  data;
      int            due;
   } req_t;

   req_t          mem_q[$];
   logic [PW-1:0] exp_q[$];
   logic [PW-1:0] cur_end = '0;
   logic [PW-1:0] mem_end = '0;
   int checks = 0, failures = 0, dones = 0, valids = 0, cyc = 0;
   logic last_br_fired = 1'b0;

   logic          stall_e = 1'b0, branch_e = 1'b0;
   logic          prev_done = 1'b0, prev_valid = 1'b0;
   logic [PW-1:0] prev_pc = '0, mon_pc;
   logic [127:0]  prev_data = ONES;

   function automatic logic [127:0] bundle(input logic [PW-1:0] pc, input logic is_end);
      logic [31:0] h;
      h = {16'h0, pc} * 32'h9E37_79B1;
      return {h, ~h, 16'hC0DE, pc, is_end, 15'h0A5A, pc};
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic load_exp(input logic [PW-1:0] s, input logic [PW-1:0] e, output int len);
      logic [PW-1:0] p;
      p = s;
      len = 0;
      exp_q.delete();
      for (int k = 0; k < 4096; k++) begin
         exp_q.push_back(p);
         len++;
         if (p == e) break;
         p = p + 1'b1;
      end
      cur_end = e;
   endtask

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      stall_e  <= stall;
      branch_e <= branch & busy;
   end

   // Monitor: compares whatever the issue register presents against the expected stream.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_pc = '0; prev_data = ONES; prev_valid = 1'b0; prev_done = 1'b0;
      end else begin
         if (branch_e) begin
            check("branch_bubble_valid", inst_valid, 1'b0);
            check("branch_bubble_data", uinstx4_out, ONES);
         end else if (stall_e) begin
            check("stall_hold_pc", pc_out, prev_pc);
            check("stall_hold_data", uinstx4_out, prev_data);
            check("stall_hold_valid", inst_valid, prev_valid);
         end else if (inst_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL extra_bundle: got pc %0h, expected no bundle", pc_out);
            end else begin
               mon_pc = exp_q.pop_front();
               check("issue_pc", pc_out, mon_pc);
               check("issue_bundle", uinstx4_out, bundle(mon_pc, mon_pc == cur_end));
               valids++;
               $display("issue pc=%h bundle=%h", pc_out, uinstx4_out);
            end
         end else begin
            check("bubble_data", uinstx4_out, ONES);
         end
         if (done) begin
            dones++;
            check("done_with_valid", inst_valid, 1'b1);
            check("done_pc", pc_out, cur_end);
            check("done_last", exp_q.size(), 0);
         end
         if (prev_done) check("busy_after_done", busy, 1'b0);
         prev_pc = pc_out; prev_data = uinstx4_out; prev_valid = inst_valid; prev_done = done;
      end
   end

   // One program: START, then per-cycle memory/stall/branch stimulus until done and drained.
   task automatic run_prog(input logic [PW-1:0] spc, input logic [PW-1:0] epc,
                           input int grant_pct, input int lat_min, input int lat_max,
                           input int stall_pct, input int br_outst,
                           input logic [PW-1:0] bpc, input logic [PW-1:0] bend,
                           input int abort_after);
      int n, d0, v0, len, blen;
      logic br_pend, finished;
      req_t r;
      n = 0; d0 = dones; v0 = valids;
      br_pend = 1'b0; finished = 1'b0; last_br_fired = 1'b0;
      @(negedge clk);
      start = 1'b1; start_pc = spc; mem_end = epc;
      @(posedge clk); #1;
      start = 1'b0;
      load_exp(spc, epc, len);
      check("busy_after_start", busy, 1'b1);
      check("req_after_start", im_req, 1'b1);
      while (!finished && n < 2000) begin
         @(negedge clk);
         n++;
         if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            r = mem_q.pop_front();
            im_valid = 1'b1;
            im_data  = r.data;
         end else begin
            im_valid = 1'b0;
            im_data  = {$urandom, $urandom, $urandom, $urandom};
         end
         im_grant = ($urandom_range(99) < grant_pct);
         if (im_req && im_grant) begin
            r.pc   = im_addr;
            r.data = bundle(im_addr, im_addr == mem_end);
            r.due  = cyc + int'($urandom_range(lat_max, lat_min));
            mem_q.push_back(r);
         end
         check("outstanding_bound", mem_q.size() <= DEPTH, 1'b1);
         stall  = ($urandom_range(99) < stall_pct);
         branch = 1'b0;
         if (br_outst > 0 && !last_br_fired && busy && !done && mem_q.size() == br_outst) begin
            branch = 1'b1; branch_pc = bpc; last_br_fired = 1'b1; br_pend = 1'b1;
            mem_end = bend;
         end
         if (abort_after > 0 && n >= abort_after) finished = 1'b1;
         @(posedge clk); #1;
         if (br_pend) begin
            load_exp(bpc, bend, blen);
            br_pend = 1'b0;
         end
         if (dones > d0 && mem_q.size() == 0) finished = 1'b1;
      end
      im_valid = 1'b0; im_grant = 1'b0; branch = 1'b0;
      if (abort_after == 0) begin
         stall = 1'b0;
         if (!finished) begin
            checks++;
            failures++;
            $display("FAIL timeout: program at %h not done in 2000 cycles, required done", spc);
         end
         check("done_count", dones - d0, 1);
         check("no_lost_bundles", exp_q.size(), 0);
         if (br_outst == 0) check("valid_count", valids - v0, len);
         check("idle_req", im_req, 1'b0);
         check("idle_busy", busy, 1'b0);
      end
   endtask

   task automatic check_reset_values();
      check("rst_pc_out", pc_out, '0);
      check("rst_uinst", uinstx4_out, ONES);
      check("rst_valid", inst_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_req", im_req, 1'b0);
      check("rst_addr", im_addr, '0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit, required completion");
      $fatal(1);
   end

   initial begin
      logic [PW-1:0] s, b;
      #2 rst_n = 1'b0;
      #1 check_reset_values();
      repeat (3) @(posedge clk);
      @(negedge clk); #2 rst_n = 1'b1;

      run_prog(16'h0010, 16'h0013, 100, 1, 1, 0, 0, '0, '0, 0);
      run_prog(16'h0020, 16'h002B, 40, 3, 3, 35, 0, '0, '0, 0);
      run_prog(16'h0030, 16'h003F, 100, 3, 3, 0, 3, 16'h0200, 16'h0205, 0);
      check("branch_fired", last_br_fired, 1'b1);
      run_prog(16'h0000, 16'h0005, 100, 3, 3, 0, 0, '0, '0, 0);
      run_prog(16'hFFFE, 16'h0000, 100, 1, 2, 0, 0, '0, '0, 0);

      run_prog(16'h0100, 16'h01FF, 100, 1, 1, 100, 0, '0, '0, 12);
      @(negedge clk);
      stall = 1'b0;
      #2 rst_n = 1'b0;
      #1 check_reset_values();
      mem_q.delete();
      exp_q.delete();
      repeat (3) @(posedge clk);
      @(negedge clk); #2 rst_n = 1'b1;
      run_prog(16'h0040, 16'h0047, 100, 1, 1, 0, 0, '0, '0, 0);

      for (int i = 0; i < 10; i++) begin
         s = PW'($urandom);
         b = PW'($urandom);
         run_prog(s, s + PW'($urandom_range(11)), int'($urandom_range(100, 30)),
                  1, int'($urandom_range(6, 1)), int'($urandom_range(50)),
                  int'($urandom_range(3)), b, b + PW'($urandom_range(9)), 0);
      end

      repeat (5) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
